// File: rtl/lif_pkg.sv
// Shared constants and helpers for the LIF neuron array.
// Config address map, reset values and a width-aware saturating add.
package lif_pkg;

    localparam logic [1:0] CFG_THRESH = 2'd0;
    localparam logic [1:0] CFG_DECAY  = 2'd1;
    localparam logic [1:0] CFG_REFRAC = 2'd2;

    // Threshold resets to all-ones; it is width dependent so it is written as '1 at the register.
    localparam int unsigned DECAY_RST   = 1;
    localparam int unsigned REFRAC_RST  = 0;
    localparam int unsigned SPIKE_CNT_W = 8;

    // a + b clamped to 2^w - 1 (w <= 31).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One leaky-integrate-and-fire neuron: potential, refractory counter, spike flag.
// Latency: spike registered on the edge that evaluates the crossing (1 cycle pulse).
// Backpressure: none; ena freezes state, clr wins over update.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int V_WIDTH   = 8,
    parameter int I_WIDTH   = 3,
    parameter int REF_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clr,
    input  logic [I_WIDTH-1:0]   current,
    input  logic [V_WIDTH-1:0]   threshold,
    input  logic [V_WIDTH-1:0]   decay,
    input  logic [REF_WIDTH-1:0] refractory,
    output logic [V_WIDTH-1:0]   v,
    output logic                 spike
`ifdef LIF_SPIKE_COUNT_EN
    ,
    output logic [SPIKE_CNT_W-1:0] spike_cnt
`endif
);

    logic [REF_WIDTH-1:0] ref_cnt;
    logic [V_WIDTH-1:0]   sum_sat;
    logic [V_WIDTH-1:0]   leaked;
    logic                 idle;
    logic                 fire;

    always_comb begin
        sum_sat = V_WIDTH'(sat_add(32'(v), 32'(current), V_WIDTH));
        leaked  = (sum_sat > decay) ? sum_sat - decay : '0;
        idle    = (ref_cnt == '0);
        // A zero threshold disables firing while integration keeps running.
        fire    = idle && (threshold != '0) && (leaked >= threshold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v       <= '0;
            ref_cnt <= '0;
            spike   <= 1'b0;
        end else if (clr) begin
            v       <= '0;
            ref_cnt <= '0;
            spike   <= 1'b0;
        end else if (!ena) begin
            spike   <= 1'b0;
        end else if (!idle) begin
            v       <= '0;
            ref_cnt <= ref_cnt - 1'b1;
            spike   <= 1'b0;
        end else if (fire) begin
            v       <= '0;
            ref_cnt <= refractory;
            spike   <= 1'b1;
        end else begin
            v       <= leaked;
            spike   <= 1'b0;
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_cnt <= '0;
        end else if (clr) begin
            spike_cnt <= '0;
        end else if (ena && fire && (spike_cnt != '1)) begin
            spike_cnt <= spike_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/lif_neuron_array.sv
// N parallel LIF neurons sharing a programmable threshold/decay/refractory bank; optional
// per-neuron saturating spike counters under LIF_SPIKE_COUNT_EN. Latency: 1 cycle to spike_out.
// Backpressure: none; ena freezes neurons, config writes always accepted.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 3,
    parameter int V_WIDTH   = 8,
    parameter int I_WIDTH   = 3,
    parameter int REF_WIDTH = 8,
    localparam int MON_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         clr,
    input  logic [N_NEURONS*I_WIDTH-1:0] in_current,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_addr,
    input  logic [V_WIDTH-1:0]           cfg_data,
    input  logic [MON_W-1:0]             mon_sel,
    output logic [V_WIDTH-1:0]           v_mon,
`ifdef LIF_SPIKE_COUNT_EN
    output logic [SPIKE_CNT_W-1:0]       spike_cnt_mon,
`endif
    output logic [N_NEURONS-1:0]         spike_out
);

    logic [V_WIDTH-1:0]   threshold;
    logic [V_WIDTH-1:0]   decay;
    logic [REF_WIDTH-1:0] refractory;
    logic [V_WIDTH-1:0]   v_arr [N_NEURONS];
`ifdef LIF_SPIKE_COUNT_EN
    logic [SPIKE_CNT_W-1:0] cnt_arr [N_NEURONS];
`endif

    // Neurons see the pre-write value; a write lands for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            threshold  <= '1;
            decay      <= V_WIDTH'(DECAY_RST);
            refractory <= REF_WIDTH'(REFRAC_RST);
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_THRESH: threshold  <= cfg_data;
                CFG_DECAY:  decay      <= cfg_data;
                CFG_REFRAC: refractory <= REF_WIDTH'(cfg_data);
                default:    ;
            endcase
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
        lif_neuron_core #(
            .V_WIDTH   (V_WIDTH),
            .I_WIDTH   (I_WIDTH),
            .REF_WIDTH (REF_WIDTH)
        ) u_core (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .clr        (clr),
            .current    (in_current[g*I_WIDTH +: I_WIDTH]),
            .threshold  (threshold),
            .decay      (decay),
            .refractory (refractory),
            .v          (v_arr[g]),
`ifdef LIF_SPIKE_COUNT_EN
            .spike_cnt  (cnt_arr[g]),
`endif
            .spike      (spike_out[g])
        );
    end

    // Unpopulated select codes read back as zero.
    always_comb begin
        v_mon = '0;
`ifdef LIF_SPIKE_COUNT_EN
        spike_cnt_mon = '0;
`endif
        for (int i = 0; i < N_NEURONS; i++) begin
            if (mon_sel == MON_W'(i)) begin
                v_mon = v_arr[i];
`ifdef LIF_SPIKE_COUNT_EN
                spike_cnt_mon = cnt_arr[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Randomized and directed bench for lif_neuron_array against an integer reference model.
module tb_lif_neuron_array;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       clr = 1'b0;
    logic [8:0] in_current = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic [1:0] mon_sel = '0;
    logic [7:0] v_mon;
    logic [2:0] spike_out;
`ifdef LIF_SPIKE_COUNT_EN
    logic [7:0] spike_cnt_mon;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state (plain integers).
    int mv [3];
    int mrc [3];
    int mcnt [3];
    bit mspk [3];
    int mthr, mdec, mref;

    lif_neuron_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clr        (clr),
        .in_current (in_current),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .mon_sel    (mon_sel),
        .v_mon      (v_mon),
`ifdef LIF_SPIKE_COUNT_EN
        .spike_cnt_mon (spike_cnt_mon),
`endif
        .spike_out  (spike_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 0; mrc[i] = 0; mcnt[i] = 0; mspk[i] = 0;
        end
        mthr = 255; mdec = 1; mref = 0;
    endtask

    task automatic model_step();
        int cur, sum, lk;
        for (int i = 0; i < 3; i++) begin
            cur = int'(in_current[i*3 +: 3]);
            if (clr) begin
                mv[i] = 0; mrc[i] = 0; mspk[i] = 0; mcnt[i] = 0;
            end else if (!ena) begin
                mspk[i] = 0;
            end else if (mrc[i] > 0) begin
                mrc[i] = mrc[i] - 1; mv[i] = 0; mspk[i] = 0;
            end else begin
                sum = mv[i] + cur;
                if (sum > 255) sum = 255;
                lk = (sum > mdec) ? sum - mdec : 0;
                if (mthr != 0 && lk >= mthr) begin
                    mspk[i] = 1; mv[i] = 0; mrc[i] = mref;
                    if (mcnt[i] < 255) mcnt[i] = mcnt[i] + 1;
                end else begin
                    mspk[i] = 0; mv[i] = lk;
                end
            end
        end
        if (cfg_we) begin
            if (cfg_addr == 2'd0) mthr = int'(cfg_data);
            else if (cfg_addr == 2'd1) mdec = int'(cfg_data);
            else if (cfg_addr == 2'd2) mref = int'(cfg_data);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic peek(input int i, output logic [7:0] val);
        mon_sel = 2'(i);
        #1;
        val = v_mon;
    endtask

    function automatic logic [2:0] model_spikes();
        logic [2:0] s;
        for (int i = 0; i < 3; i++) s[i] = mspk[i];
        return s;
    endfunction

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] val;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (spike_out !== 3'b000) begin
            failures++; $display("FAIL reset_spike got %b exp 000", spike_out);
        end
        for (int i = 0; i < 3; i++) begin
            peek(i, val);
            checks++;
            if (val !== 8'd0) begin
                failures++; $display("FAIL reset_v n%0d got %0d exp 0", i, val);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_current = {3'd7, 3'd7, 3'd7};
        ena = 1'b1;
        for (int k = 0; k < 45; k++) begin
            step();
            checks++;
            if (spike_out !== 3'b000) begin
                failures++; $display("FAIL reset_defaults_spike cyc %0d got %b exp 000", k, spike_out);
            end
            for (int i = 0; i < 3; i++) begin
                peek(i, val);
                checks++;
                if (val !== 8'(mv[i])) begin
                    failures++; $display("FAIL reset_defaults_v n%0d cyc %0d got %0d exp %0d", i, k, val, mv[i]);
                end
            end
        end
        peek(0, val);
        checks++;
        if (val !== 8'd254) begin
            failures++; $display("FAIL reset_saturate got %0d exp 254", val);
        end
    endtask

    task automatic test_basic_fire();
        int exp_v [9] = '{2, 4, 6, 8, 0, 0, 0, 2, 4};
        bit exp_s [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic [7:0] val;
        ena = 1'b0; in_current = '0;
        clr = 1'b1;
        cfg_write(2'd0, 8'd10);
        clr = 1'b0;
        cfg_write(2'd1, 8'd1);
        cfg_write(2'd2, 8'd2);
        in_current = 9'd3; ena = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            peek(0, val);
            checks++;
            if (val !== 8'(exp_v[k]) || val !== 8'(mv[0])) begin
                failures++; $display("FAIL basic_fire_v edge %0d got %0d exp %0d", k + 1, val, exp_v[k]);
            end
            checks++;
            if (spike_out[0] !== exp_s[k]) begin
                failures++; $display("FAIL basic_fire_spike edge %0d got %b exp %b", k + 1, spike_out[0], exp_s[k]);
            end
        end
    endtask

    task automatic test_leak_floor();
        logic [7:0] val;
        ena = 1'b0; clr = 1'b1;
        cfg_write(2'd0, 8'd20);
        clr = 1'b0;
        cfg_write(2'd1, 8'd5);
        in_current = {3'd3, 3'd3, 3'd3}; ena = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            peek(0, val);
            checks++;
            if (val !== 8'd0 || spike_out !== 3'b000) begin
                failures++; $display("FAIL leak_floor edge %0d got v=%0d s=%b exp v=0 s=000", k, val, spike_out);
            end
        end
        // Write lands with ena=1: the edge of the write still uses decay 5.
        cfg_write(2'd1, 8'd1);
        peek(0, val);
        checks++;
        if (val !== 8'd0) begin
            failures++; $display("FAIL leak_write_edge got %0d exp 0", val);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            peek(0, val);
            checks++;
            if (val !== 8'(2 * k) || val !== 8'(mv[0])) begin
                failures++; $display("FAIL leak_climb step %0d got %0d exp %0d", k, val, 2 * k);
            end
        end
    endtask

    task automatic test_channels();
        logic [7:0] val;
        ena = 1'b0; clr = 1'b1;
        cfg_write(2'd0, 8'd12);
        clr = 1'b0;
        cfg_write(2'd1, 8'd1);
        in_current = {3'd0, 3'd1, 3'd7}; ena = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (spike_out !== model_spikes() || spike_out[2:1] !== 2'b00) begin
                failures++; $display("FAIL channels_spike edge %0d got %b exp %b", k, spike_out, model_spikes());
            end
            if (k == 2) begin
                checks++;
                if (spike_out[0] !== 1'b1) begin
                    failures++; $display("FAIL channels_fire0 got %b exp 1", spike_out[0]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                peek(i, val);
                checks++;
                if (val !== 8'd0) begin
                    failures++; $display("FAIL channels_v n%0d edge %0d got %0d exp 0", i, k, val);
                end
            end
        end
    endtask

    task automatic test_freeze_clear();
        logic [7:0] val;
        logic [7:0] snap [3];
        ena = 1'b0; clr = 1'b1;
        cfg_write(2'd0, 8'd200);
        clr = 1'b0;
        cfg_write(2'd2, 8'd0);
        in_current = {3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)), 3'($urandom_range(2, 7))};
        ena = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 3; i++) peek(i, snap[i]);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_current = 9'($urandom);
            step();
            checks++;
            if (spike_out !== 3'b000) begin
                failures++; $display("FAIL freeze_spike cyc %0d got %b exp 000", k, spike_out);
            end
            for (int i = 0; i < 3; i++) begin
                peek(i, val);
                checks++;
                if (val !== snap[i] || val !== 8'(mv[i])) begin
                    failures++; $display("FAIL freeze_v n%0d got %0d exp %0d", i, val, mv[i]);
                end
            end
        end
        clr = 1'b1;
        cfg_write(2'd0, 8'd10);
        clr = 1'b0;
        cfg_write(2'd2, 8'd5);
        in_current = 9'd7; ena = 1'b1;
        step(); step();
        checks++;
        if (spike_out[0] !== 1'b1) begin
            failures++; $display("FAIL clear_setup_spike got %b exp 1", spike_out[0]);
        end
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        peek(0, val);
        checks++;
        if (val !== 8'd0 || spike_out !== 3'b000) begin
            failures++; $display("FAIL clear_refrac got v=%0d s=%b exp v=0 s=000", val, spike_out);
        end
        step();
        peek(0, val);
        checks++;
        if (val !== 8'd6) begin
            failures++; $display("FAIL clear_resume got %0d exp 6", val);
        end
        ena = 1'b0;
        cfg_write(2'd0, 8'd0);
        cfg_write(2'd1, 8'd0);
        ena = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            checks++;
            if (spike_out !== 3'b000) begin
                failures++; $display("FAIL thr0_spike cyc %0d got %b exp 000", k, spike_out);
            end
        end
        peek(0, val);
        checks++;
        if (val !== 8'd255 || val !== 8'(mv[0])) begin
            failures++; $display("FAIL thr0_saturate got %0d exp 255", val);
        end
    endtask

    task automatic test_random();
        logic [7:0] val;
        ena = 1'b0; clr = 1'b1;
        step();
        for (int k = 0; k < 400; k++) begin
            ena = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 29) == 0);
            in_current = 9'($urandom);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_data = (cfg_addr == 2'd0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 4));
            step();
            cfg_we = 1'b0;
            checks++;
            if (spike_out !== model_spikes()) begin
                failures++; $display("FAIL random_spike cyc %0d got %b exp %b", k, spike_out, model_spikes());
            end
            for (int i = 0; i < 3; i++) begin
                peek(i, val);
                checks++;
                if (val !== 8'(mv[i])) begin
                    failures++; $display("FAIL random_v n%0d cyc %0d got %0d exp %0d", i, k, val, mv[i]);
                end
            end
        end
        mon_sel = 2'd3;
        #1;
        checks++;
        if (v_mon !== 8'd0) begin
            failures++; $display("FAIL mon_out_of_range got %0d exp 0", v_mon);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] val;
        ena = 1'b0; clr = 1'b1;
        cfg_write(2'd0, 8'd10);
        clr = 1'b0;
        cfg_write(2'd1, 8'd1);
        cfg_write(2'd2, 8'd20);
        in_current = 9'd7; ena = 1'b1;
        step(); step();
        checks++;
        if (spike_out[0] !== 1'b1) begin
            failures++; $display("FAIL arst_setup_spike got %b exp 1", spike_out[0]);
        end
        step();
        peek(0, val);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (spike_out !== 3'b000 || v_mon !== 8'd0) begin
            failures++; $display("FAIL arst_immediate got s=%b v=%0d exp s=000 v=0", spike_out, v_mon);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_current = {3'd7, 3'd7, 3'd7};
        step(); step();
        peek(0, val);
        checks++;
        if (val !== 8'd12 || spike_out !== 3'b000) begin
            failures++; $display("FAIL arst_defaults got v=%0d s=%b exp v=12 s=000", val, spike_out);
        end
    endtask

`ifdef LIF_SPIKE_COUNT_EN
    task automatic test_spike_count();
        ena = 1'b0; clr = 1'b1;
        cfg_write(2'd0, 8'd1);
        clr = 1'b0;
        cfg_write(2'd1, 8'd0);
        cfg_write(2'd2, 8'd0);
        in_current = 9'd7; ena = 1'b1;
        repeat (300) step();
        mon_sel = 2'd0;
        #1;
        checks++;
        if (spike_cnt_mon !== 8'd255 || spike_cnt_mon !== 8'(mcnt[0])) begin
            failures++; $display("FAIL spike_cnt_sat got %0d exp 255", spike_cnt_mon);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        checks++;
        if (spike_cnt_mon !== 8'd0) begin
            failures++; $display("FAIL spike_cnt_clr got %0d exp 0", spike_cnt_mon);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic_fire();
        test_leak_floor();
        test_channels();
        test_freeze_clear();
        test_random();
`ifdef LIF_SPIKE_COUNT_EN
        test_spike_count();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
